// File: rtl/controle_pkg.sv
// Shared definitions for the parametrised tic-tac-toe game controller:
// state encoding (equal to db_estado) and the width helper for the player index.
package controle_pkg;

  localparam int unsigned EstadoW = 4;

  typedef enum logic [EstadoW-1:0] {
    StInicial           = 4'h0,
    StPreparacao        = 4'h1,
    StJogaMacro         = 4'h2,
    StRegistraMacro     = 4'h3,
    StValidaMacro       = 4'h4,
    StJogaMicro         = 4'h5,
    StRegistraMicro     = 4'h6,
    StValidaMicro       = 4'h7,
    StRegistraJogada    = 4'h8,
    StVerificaMacro     = 4'h9,
    StRegistraResultado = 4'hA,
    StVerificaTabuleiro = 4'hB,
    StTrocaJogador      = 4'hC,
    StDecideMacro       = 4'hD,
    StTimeout           = 4'hE,
    StFim               = 4'hF
  } estado_e;

  function automatic int unsigned jogador_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unidade_controle_param_if.sv
// Handshake bundle between the game controller and its datapath / player inputs.
interface unidade_controle_param_if import controle_pkg::*; #(
  parameter int unsigned N_JOGADORES = 2
) ();

  localparam int unsigned JogW = jogador_w(N_JOGADORES);

  logic                iniciar;
  logic                tem_jogada;
  logic                fim_jogo;
  logic                macro_vencida;
  logic                micro_jogada;
  logic [JogW-1:0]     jogador;
  logic                sinal_macro;
  logic                sinal_valida_macro;
  logic                zeraR_macro;
  logic                zeraR_micro;
  logic                zeraEdge;
  logic                zeraRAM;
  logic                registraR_macro;
  logic                registraR_micro;
  logic                we_board;
  logic                we_board_state;
  logic                pronto;
  logic                jogar_macro;
  logic                jogar_micro;
  logic                timeout_flag;
  logic [EstadoW-1:0]  db_estado;

  modport master (
    output iniciar, tem_jogada, fim_jogo, macro_vencida, micro_jogada,
    input  jogador, sinal_macro, sinal_valida_macro, zeraR_macro, zeraR_micro, zeraEdge,
           zeraRAM, registraR_macro, registraR_micro, we_board, we_board_state, pronto,
           jogar_macro, jogar_micro, timeout_flag, db_estado
  );

  modport slave (
    input  iniciar, tem_jogada, fim_jogo, macro_vencida, micro_jogada,
    output jogador, sinal_macro, sinal_valida_macro, zeraR_macro, zeraR_micro, zeraEdge,
           zeraRAM, registraR_macro, registraR_micro, we_board, we_board_state, pronto,
           jogar_macro, jogar_micro, timeout_flag, db_estado
  );

endinterface

// File: rtl/contador_param.sv
// Up-counter with synchronous clear that holds at its terminal value and flags it.
module contador_param #(
  parameter int unsigned Terminal = 3,
  parameter int unsigned Width    = (Terminal > 0) ? $clog2(Terminal + 1) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [Width-1:0] TermVal = Width'(Terminal);

  logic [Width-1:0] cnt_q, cnt_d;

  assign fim = (cnt_q == TermVal);

  // Holding at terminal keeps the flag asserted while waiting for a late input.
  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta && !fim) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unidade_controle_param.sv
// Moore controller for N-player ultimate tic-tac-toe with internal settle/validation
// timers and a per-move forfeit timeout.
module unidade_controle_param import controle_pkg::*; #(
  parameter int unsigned N_JOGADORES = 2,
  parameter int unsigned T_ESPERA    = 4,
  parameter int unsigned T_VALIDA    = 8,
  parameter int unsigned T_TIMEOUT   = 1000,
  parameter bit          TIMEOUT_EN  = 1'b1
) (
  input logic                     clock,
  input logic                     reset,
  unidade_controle_param_if.slave ctl
);

  localparam int unsigned JogW = jogador_w(N_JOGADORES);
  localparam logic [JogW-1:0] JogMax = JogW'(N_JOGADORES - 1);

  estado_e         estado_q, estado_d;
  logic [JogW-1:0] jogador_q, jogador_d;
  logic            macro_ok_q, macro_ok_d;
  logic            pulou_q, pulou_d;
  logic            fim_s, fim_t, fim_to, expira, muda;
  logic            conta_s, conta_t, conta_to;

  assign muda     = (estado_d != estado_q);
  assign conta_to = (estado_q == StJogaMacro) || (estado_q == StJogaMicro);
  assign conta_s  = conta_to || (estado_q == StRegistraJogada) ||
                    (estado_q == StRegistraResultado) || (estado_q == StTrocaJogador);
  assign conta_t  = (estado_q == StValidaMacro) || (estado_q == StValidaMicro) ||
                    (estado_q == StFim);
  assign expira   = TIMEOUT_EN && fim_to;

  contador_param #(.Terminal(T_ESPERA - 1)) u_cnt_s (
    .clock (clock),
    .reset (reset),
    .zera  (muda),
    .conta (conta_s),
    .fim   (fim_s)
  );

  contador_param #(.Terminal(T_VALIDA - 1)) u_cnt_t (
    .clock (clock),
    .reset (reset),
    .zera  (muda),
    .conta (conta_t),
    .fim   (fim_t)
  );

  contador_param #(.Terminal(T_TIMEOUT - 1)) u_cnt_to (
    .clock (clock),
    .reset (reset),
    .zera  (muda),
    .conta (conta_to),
    .fim   (fim_to)
  );

  always_comb begin
    estado_d   = estado_q;
    jogador_d  = jogador_q;
    macro_ok_d = macro_ok_q;
    pulou_d    = pulou_q;
    unique case (estado_q)
      StInicial: if (ctl.iniciar) begin
        estado_d  = StPreparacao;
        jogador_d = '0;
      end
      StPreparacao: begin
        estado_d   = StJogaMacro;
        macro_ok_d = 1'b0;
      end
      StJogaMacro: begin
        if (expira) estado_d = StTimeout;
        else if (fim_s && ctl.tem_jogada) estado_d = StRegistraMacro;
      end
      StRegistraMacro: estado_d = StValidaMacro;
      StValidaMacro: if (fim_t) begin
        if (ctl.macro_vencida) begin
          estado_d = StPreparacao;
        end else begin
          estado_d   = StJogaMicro;
          macro_ok_d = 1'b1;
        end
      end
      StJogaMicro: begin
        if (expira) estado_d = StTimeout;
        else if (fim_s && ctl.tem_jogada) estado_d = StRegistraMicro;
      end
      StRegistraMicro: estado_d = StValidaMicro;
      StValidaMicro: if (fim_t) begin
        estado_d = ctl.micro_jogada ? StJogaMicro : StRegistraJogada;
      end
      StRegistraJogada: if (fim_s) estado_d = StVerificaMacro;
      StVerificaMacro: estado_d = StRegistraResultado;
      StRegistraResultado: if (fim_s) estado_d = StVerificaTabuleiro;
      StVerificaTabuleiro: estado_d = ctl.fim_jogo ? StFim : StTrocaJogador;
      StTrocaJogador: if (fim_s) estado_d = StDecideMacro;
      StDecideMacro: begin
        // After a forfeit the next player keeps the macro already chosen, if any.
        if (pulou_q) begin
          estado_d = macro_ok_q ? StJogaMicro : StPreparacao;
          pulou_d  = 1'b0;
        end else begin
          estado_d = ctl.macro_vencida ? StPreparacao : StJogaMicro;
        end
      end
      StTimeout: begin
        estado_d = StTrocaJogador;
        pulou_d  = 1'b1;
      end
      StFim: if (fim_t && ctl.iniciar) estado_d = StInicial;
    endcase
    if ((estado_d == StTrocaJogador) && (estado_q != StTrocaJogador)) begin
      jogador_d = (jogador_q == JogMax) ? '0 : jogador_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= StInicial;
      jogador_q  <= '0;
      macro_ok_q <= 1'b0;
      pulou_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      jogador_q  <= jogador_d;
      macro_ok_q <= macro_ok_d;
      pulou_q    <= pulou_d;
    end
  end

  always_comb begin
    ctl.sinal_macro        = 1'b0;
    ctl.sinal_valida_macro = 1'b0;
    ctl.zeraR_macro        = 1'b0;
    ctl.zeraR_micro        = 1'b0;
    ctl.zeraEdge           = 1'b0;
    ctl.zeraRAM            = 1'b0;
    ctl.registraR_macro    = 1'b0;
    ctl.registraR_micro    = 1'b0;
    ctl.we_board           = 1'b0;
    ctl.we_board_state     = 1'b0;
    ctl.pronto             = 1'b0;
    ctl.jogar_macro        = 1'b0;
    ctl.jogar_micro        = 1'b0;
    ctl.timeout_flag       = 1'b0;
    case (estado_q)
      StInicial: begin
        ctl.zeraR_macro = 1'b1;
        ctl.zeraR_micro = 1'b1;
        ctl.zeraEdge    = 1'b1;
        ctl.zeraRAM     = 1'b1;
      end
      StPreparacao: begin
        ctl.zeraR_macro = 1'b1;
        ctl.zeraR_micro = 1'b1;
      end
      StJogaMacro: begin
        ctl.sinal_macro = 1'b1;
        ctl.jogar_macro = 1'b1;
      end
      StRegistraMacro: begin
        ctl.registraR_macro    = 1'b1;
        ctl.sinal_macro        = 1'b1;
        ctl.sinal_valida_macro = 1'b1;
      end
      StValidaMacro: ctl.sinal_valida_macro = 1'b1;
      StJogaMicro: begin
        ctl.zeraR_micro = 1'b1;
        ctl.jogar_micro = 1'b1;
      end
      StRegistraMicro: ctl.registraR_micro = 1'b1;
      StRegistraJogada: ctl.we_board = 1'b1;
      StRegistraResultado: begin
        ctl.we_board_state     = 1'b1;
        ctl.sinal_valida_macro = 1'b1;
      end
      StDecideMacro: ctl.registraR_macro = !pulou_q;
      StTimeout: ctl.timeout_flag = 1'b1;
      StFim: ctl.pronto = 1'b1;
      default: ;
    endcase
  end

  assign ctl.jogador   = jogador_q;
  assign ctl.db_estado = estado_q;

endmodule

// File: doc/unidade_controle_param.md
Name: unidade_controle_param

Overview:
- Parametrised successor to the ultimate tic-tac-toe game controller (Moore FSM).
- Sequences macro-board choice, micro-cell choice, validation, board/state RAM writes and end-of-game detection for N players.
- Settle and validation counters move inside the block, replacing the external fimS/fimT inputs.
- Adds a per-move timeout: an idle player forfeits the turn and play passes to the next player.

Parameters:
- N_JOGADORES, 2, number of players (>=2); turn index wraps modulo N_JOGADORES.
- T_ESPERA, 4, cycles spent in each settle/write/handoff state (>=1).
- T_VALIDA, 8, cycles spent in each validation state and in FIM before iniciar is honoured (>=1).
- T_TIMEOUT, 1000, cycles allowed in JOGA_MACRO/JOGA_MICRO before forfeit (>T_ESPERA).
- TIMEOUT_EN, 1, 0 disables the forfeit path entirely.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces INICIAL.
- iniciar  in  1  start / restart request.
- tem_jogada  in  1  move present (edge-detected upstream).
- fim_jogo  in  1  whole board decided.
- macro_vencida  in  1  addressed macro already won or full.
- micro_jogada  in  1  addressed micro cell already occupied.
- jogador  out  $clog2(N_JOGADORES)  current player index.
- sinal_macro, sinal_valida_macro, zeraR_macro, zeraR_micro, zeraEdge, zeraRAM, registraR_macro, registraR_micro, we_board, we_board_state, pronto, jogar_macro, jogar_micro  out  1 each  datapath controls, same meaning as the previous generation.
- timeout_flag  out  1  one-cycle pulse on forfeit.
- db_estado  out  4  state code.

Behaviour:
- State codes: INICIAL 0, PREPARACAO 1, JOGA_MACRO 2, REGISTRA_MACRO 3, VALIDA_MACRO 4, JOGA_MICRO 5, REGISTRA_MICRO 6, VALIDA_MICRO 7, REGISTRA_JOGADA 8, VERIFICA_MACRO 9, REGISTRA_RESULTADO A, VERIFICA_TABULEIRO B, TROCA_JOGADOR C, DECIDE_MACRO D, TIMEOUT E, FIM F.
- db_estado equals the state code. All 16 codes are legal.
- Reset: state INICIAL, all counters 0, jogador 0, flags macro_ok/pulou 0.
- Outputs are Moore, decoded from the current state. While reset is asserted, outputs take their INICIAL values: zeraR_macro, zeraR_micro, zeraEdge, zeraRAM = 1; all others 0.
- cnt_s counts cycles while in JOGA_*, REGISTRA_JOGADA, REGISTRA_RESULTADO and TROCA_JOGADOR. fimS = (cnt_s == T_ESPERA-1). cnt_s clears on every state change.
- cnt_t counts cycles while in VALIDA_* and FIM. fimT = (cnt_t == T_VALIDA-1). cnt_t clears on every state change.
- cnt_to counts cycles while in JOGA_*. It clears on every state change.
- Transitions:
  - INICIAL -> PREPARACAO when iniciar = 1; jogador := 0.
  - PREPARACAO -> JOGA_MACRO; macro_ok := 0.
  - JOGA_x: if TIMEOUT_EN and cnt_to == T_TIMEOUT-1 -> TIMEOUT. Otherwise, if fimS and tem_jogada -> REGISTRA_x.
  - Timeout has priority over a move arriving in the same cycle.
  - REGISTRA_x -> VALIDA_x.
  - VALIDA_MACRO after fimT: macro_vencida -> PREPARACAO; else -> JOGA_MICRO and macro_ok := 1.
  - VALIDA_MICRO after fimT: micro_jogada -> JOGA_MICRO; else -> REGISTRA_JOGADA.
  - REGISTRA_JOGADA (fimS) -> VERIFICA_MACRO -> REGISTRA_RESULTADO (fimS) -> VERIFICA_TABULEIRO.
  - VERIFICA_TABULEIRO: fim_jogo -> FIM; else -> TROCA_JOGADOR.
  - TIMEOUT: timeout_flag = 1; pulou := 1; -> TROCA_JOGADOR after one cycle.
  - TROCA_JOGADOR (fimS) -> DECIDE_MACRO. jogador increments once, on entry: wraps N_JOGADORES-1 -> 0.
  - DECIDE_MACRO when pulou = 1: no registraR_macro; -> JOGA_MICRO if macro_ok, else -> PREPARACAO; pulou := 0.
  - DECIDE_MACRO when pulou = 0: registraR_macro = 1; macro_vencida -> PREPARACAO, else -> JOGA_MICRO.
  - FIM: pronto = 1; after fimT, iniciar -> INICIAL. iniciar is ignored before fimT.
- Output decode (1 in the listed states):
  - zeraR_macro: INICIAL, PREPARACAO.
  - zeraR_micro: INICIAL, PREPARACAO, JOGA_MICRO.
  - zeraEdge, zeraRAM: INICIAL.
  - registraR_macro: REGISTRA_MACRO, and DECIDE_MACRO when pulou = 0.
  - registraR_micro: REGISTRA_MICRO.
  - sinal_macro: JOGA_MACRO, REGISTRA_MACRO.
  - sinal_valida_macro: REGISTRA_MACRO, VALIDA_MACRO, REGISTRA_RESULTADO.
  - we_board: REGISTRA_JOGADA.
  - we_board_state: REGISTRA_RESULTADO.
  - jogar_macro: JOGA_MACRO.
  - jogar_micro: JOGA_MICRO.
- we_board and we_board_state are high for exactly T_ESPERA cycles per move.
- Reset deasserting mid-game: the block resumes from INICIAL with no pending writes.

Decomposition:
- Shared package controle_pkg holds: state localparams, db_estado codes, and the width function for jogador.
- One sub-module: contador_param (parametrised width, clear/enable, terminal-count flag), instantiated three times for cnt_s, cnt_t and cnt_to.

Test Plan:
- Reset low mid-REGISTRA_JOGADA -> db_estado = 0 immediately, we_board = 0, jogador = 0, zeraRAM = 1.
- T_ESPERA=4, T_VALIDA=8: iniciar; legal macro, then legal micro, with fim_jogo = 0 -> we_board high exactly 4 cycles, jogador 0 -> 1, then JOGA_MICRO.
- VALIDA_MACRO with macro_vencida = 1 -> back to state 1; no we_board pulse.
- T_TIMEOUT=20, no tem_jogada in JOGA_MICRO -> state E on the 20th cycle, timeout_flag pulse of 1 cycle, jogador advances, next state JOGA_MICRO with no registraR_macro pulse.
- N_JOGADORES=3 with three consecutive moves -> jogador sequence 0, 1, 2, 0; tem_jogada coincident with timeout -> TIMEOUT is taken.
- fim_jogo = 1 at VERIFICA_TABULEIRO -> state F, pronto = 1; iniciar at cycle 3 in FIM ignored; iniciar after cycle 8 -> state 0.
